// File: rtl/pwm_dac_tone_gen_pkg.sv
// pwm_dac_tone_gen shared constants: widths, tuning words, sine LUT.
// Tuning words assume a 50 MHz clock and fs = 50e6/256.
package pwm_dac_pkg;

  localparam int PWM_BITS      = 8;
  localparam int PHASE_BITS    = 24;
  localparam int LUT_ADDR_BITS = 6;

  typedef logic [1:0]            sel_t;
  typedef logic [PHASE_BITS-1:0] phase_t;
  typedef logic [PWM_BITS-1:0]   duty_t;

  localparam duty_t MID = duty_t'(1 << (PWM_BITS - 1));

  localparam phase_t TW [4] = '{
    24'd0, 24'd37796, 24'd85899, 24'd171799
  };

  localparam logic [6:0] QLUT [2**LUT_ADDR_BITS] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
  };

  function automatic duty_t sine_sample(logic [7:0] p);
    logic [LUT_ADDR_BITS-1:0] i;
    duty_t                    mag;
    i   = p[6] ? ~p[5:0] : p[5:0];
    mag = {1'b0, QLUT[i]};
    return p[7] ? MID - mag : MID + mag;
  endfunction

endpackage

// File: rtl/pwm_dac_tone_gen_if.sv
// pwm_dac_tone_gen pin bundle: tone select in, PWM and debug out.
// master = system side, slave = tone generator.
interface pwm_dac_tone_gen_if;
  import pwm_dac_pkg::*;

  sel_t  frequency_export;
  logic  pwm_out;
  logic  sample_tick;
  duty_t sample_dbg;

  modport master (
    output frequency_export,
    input  pwm_out,
    input  sample_tick,
    input  sample_dbg
  );

  modport slave (
    input  frequency_export,
    output pwm_out,
    output sample_tick,
    output sample_dbg
  );

endinterface

// File: rtl/pwm_dac_tone_gen_modulator.sv
// pwm_modulator: free-running counter, duty reload at wrap,
// period tick and registered PWM bit.
module pwm_modulator
  import pwm_dac_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  duty_t sample,
  output logic  tick,
  output logic  pwm_out,
  output duty_t duty_reg
);

  duty_t pwm_cnt;

  assign tick = &pwm_cnt;

  // counter, duty reload on the last count, registered compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt  <= '0;
      duty_reg <= MID;
      pwm_out  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm_out <= (pwm_cnt < duty_reg);
      if (tick) duty_reg <= sample;
    end
  end

endmodule

// File: rtl/pwm_dac_tone_gen.sv
// pwm_dac_tone_gen: select synchronizer, phase accumulator and
// quarter-wave sine lookup feeding the PWM modulator.
module pwm_dac_tone_gen
  import pwm_dac_pkg::*;
(
  input logic               clk_clk,
  input logic               reset_reset_n,
  pwm_dac_tone_gen_if.slave io
);

  sel_t   sel_meta;
  sel_t   sel_sync;
  sel_t   sel_active;
  phase_t phase;
  duty_t  sample_reg;
  duty_t  duty_reg;
  logic   tick;

  // two-flop synchronizer for the PIO select
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sel_meta <= '0;
      sel_sync <= '0;
    end else begin
      sel_meta <= io.frequency_export;
      sel_sync <= sel_meta;
    end
  end

  // phase step and select update only at the period boundary
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sel_active <= '0;
      phase      <= '0;
    end else if (tick) begin
      sel_active <= sel_sync;
      if (sel_sync == '0) phase <= '0;
      else                phase <= phase + TW[sel_active];
    end
  end

  // sine lookup, silence at mid-scale when the tone is off
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) sample_reg <= MID;
    else if (sel_active == '0) sample_reg <= MID;
    else sample_reg <= sine_sample(phase[PHASE_BITS-1 -: 8]);
  end

  pwm_modulator u_mod (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .sample   (sample_reg),
    .tick     (tick),
    .pwm_out  (io.pwm_out),
    .duty_reg (duty_reg)
  );

  assign io.sample_tick = tick;
  assign io.sample_dbg  = duty_reg;

endmodule
